// File: rtl/fpu_pipe_pkg.sv
// Shared constants and helpers for the elastic FPU pipeline register chain.
// The optional stall counter (macro FPU_PIPE_STALL_CNT_EN) uses the width
// and saturation constants defined here.
package fpu_pipe_pkg;

    // Width of the optional output-stall counter.
    localparam int STALL_CNT_W = 16;

    // The stall counter sticks at this value instead of wrapping.
    localparam logic [STALL_CNT_W-1:0] STALL_CNT_SAT = 16'hFFFF;

    // Bits needed to count 0..stages valid stages.
    function automatic int occ_width(input int stages);
        return $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/fpu_pipe_stage.sv
// One valid/data stage of the elastic chain. The stage loads whenever it is
// ready (computed by the chain from its own valid bit and the downstream
// readiness); an invalid source turns it into a bubble but keeps old data.
module fpu_pipe_stage #(
    parameter int P = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_flush,
    input  logic         i_ready,
    input  logic         i_src_valid,
    input  logic [P-1:0] i_src_data,
    output logic         o_valid,
    output logic [P-1:0] o_data
);

    logic         r_valid;
    logic [P-1:0] r_data;

    // Stage register: reset clears everything, flush clears only the valid bit.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_data  <= {P{1'b0}};
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_ready) begin
            r_valid <= i_src_valid;
            if (i_src_valid) begin
                r_data <= i_src_data;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/fpu_pipe_chain.sv
// Elastic pipeline register chain: S stages of P-bit payload with a
// combinational ready chain (bubbles collapse), synchronous flush and a
// registered occupancy count. Defining FPU_PIPE_STALL_CNT_EN adds a
// saturating STALL_CNT output counting cycles the output is blocked.
module fpu_pipe_chain
    import fpu_pipe_pkg::*;
#(
    parameter  int P  = 32,
    parameter  int S  = 3,
    localparam int CW = occ_width(S)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          FLUSH,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic [P-1:0]  IN_DATA,
    output logic          OUT_VALID,
    input  logic          OUT_READY,
    output logic [P-1:0]  OUT_DATA,
    output logic [CW-1:0] OCC
`ifdef FPU_PIPE_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] STALL_CNT
`endif
);

    logic [S-1:0] w_valid;
    logic [S-1:0] w_ready;
    logic [S-1:0] w_src_valid;
    logic [P-1:0] w_data     [S];
    logic [P-1:0] w_src_data [S];
    logic         w_carry;
    logic         w_in_hs;
    logic         w_out_hs;
    logic [CW-1:0] r_occ;

    // Ready chain from the output side back to the input: a stage may load
    // when it is empty or when the stage after it can move.
    always_comb begin
        w_ready = {S{1'b0}};
        w_carry = OUT_READY;
        for (int k = S - 1; k >= 0; k--) begin
            w_ready[k] = ~w_valid[k] | w_carry;
            w_carry    = w_ready[k];
        end
    end

    genvar k;
    generate
        for (k = 0; k < S; k++) begin : g_stage
            if (k == 0) begin : g_src_in
                assign w_src_valid[k] = IN_VALID;
                assign w_src_data[k]  = IN_DATA;
            end else begin : g_src_prev
                assign w_src_valid[k] = w_valid[k-1];
                assign w_src_data[k]  = w_data[k-1];
            end

            fpu_pipe_stage #(.P(P)) u_stage (
                .i_clk       (CLK),
                .i_rst       (RST),
                .i_flush     (FLUSH),
                .i_ready     (w_ready[k]),
                .i_src_valid (w_src_valid[k]),
                .i_src_data  (w_src_data[k]),
                .o_valid     (w_valid[k]),
                .o_data      (w_data[k])
            );
        end
    endgenerate

    assign IN_READY  = w_ready[0] & ~FLUSH & ~RST;
    assign OUT_VALID = w_valid[S-1];
    assign OUT_DATA  = w_data[S-1];
    assign w_in_hs   = IN_VALID & IN_READY;
    assign w_out_hs  = OUT_VALID & OUT_READY;

    // Occupancy tracks the number of valid stages via the two handshakes.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_occ <= {CW{1'b0}};
        end else if (FLUSH) begin
            r_occ <= {CW{1'b0}};
        end else begin
            case ({w_in_hs, w_out_hs})
                2'b10:   r_occ <= r_occ + CW'(1);
                2'b01:   r_occ <= r_occ - CW'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign OCC = r_occ;

`ifdef FPU_PIPE_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    // Count cycles where the output holds data the consumer refuses; sticks at max.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stall_cnt <= {STALL_CNT_W{1'b0}};
        end else if (FLUSH) begin
            r_stall_cnt <= {STALL_CNT_W{1'b0}};
        end else if (OUT_VALID && !OUT_READY && (r_stall_cnt != STALL_CNT_SAT)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign STALL_CNT = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fpu_pipe_chain.sv
// Scoreboard bench for fpu_pipe_chain (P=32, S=3): accepted inputs are queued
// with their expected value, a negedge monitor pops and compares each output
// transfer. Directed checks cover reset, streaming latency, backpressure,
// bubble collapse, flush and (with FPU_PIPE_STALL_CNT_EN) the stall counter.
module tb_fpu_pipe_chain;

    localparam int P  = 32;
    localparam int S  = 3;
    localparam int CW = $clog2(S + 1);

    logic          CLK = 1'b0;
    logic          RST;
    logic          FLUSH;
    logic          IN_VALID;
    logic [P-1:0]  IN_DATA;
    logic          OUT_READY;
    wire           IN_READY;
    wire           OUT_VALID;
    wire  [P-1:0]  OUT_DATA;
    wire  [CW-1:0] OCC;
`ifdef FPU_PIPE_STALL_CNT_EN
    wire  [15:0]   STALL_CNT;
`endif

    fpu_pipe_chain #(.P(P), .S(S)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .FLUSH     (FLUSH),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .IN_DATA   (IN_DATA),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_DATA  (OUT_DATA),
        .OCC       (OCC)
`ifdef FPU_PIPE_STALL_CNT_EN
        ,
        .STALL_CNT (STALL_CNT)
`endif
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int pops   = 0;
    int occ_max = 0;
    bit mon_en  = 1'b0;
    bit lat_chk = 1'b0;

    typedef struct {
        logic [P-1:0] data;
        int           exp_cyc;
    } exp_t;
    exp_t sb[$];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: queue accepted inputs, compare every output transfer.
    always @(negedge CLK) begin
        exp_t e;
        if (mon_en) begin
            if (int'(OCC) > occ_max) occ_max = int'(OCC);
            if (IN_VALID === 1'b1 && IN_READY === 1'b1)
                sb.push_back('{data: IN_DATA, exp_cyc: (lat_chk ? cyc + 3 : -1)});
            if (OUT_VALID === 1'b1 && OUT_READY === 1'b1 && FLUSH === 1'b0 && RST === 1'b0) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got %0h expected no output", OUT_DATA);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", OUT_DATA, e.data);
                    if (e.exp_cyc >= 0) chk("out_latency", cyc, e.exp_cyc);
                    pops++;
                end
            end
        end
    end

    task automatic nxt();
        @(posedge CLK);
        #1;
    endtask

    logic [P-1:0] stream_vec [3] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000};
    bit           bp_rdy     [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    int           pops0;

    initial begin
        RST = 1'b1; FLUSH = 1'b0; IN_VALID = 1'b1; IN_DATA = 32'hDEAD_BEEF; OUT_READY = 1'b1;
        nxt(); nxt();
        @(negedge CLK);
        chk("rst_out_valid", OUT_VALID, 1'b0);
        chk("rst_out_data", OUT_DATA, 32'h0);
        chk("rst_occ", OCC, 0);
        chk("rst_in_ready_low", IN_READY, 1'b0);
        nxt();
        RST = 1'b0; IN_VALID = 1'b0; mon_en = 1'b1;
        @(negedge CLK);
        chk("post_rst_in_ready", IN_READY, 1'b1);
        chk("post_rst_occ", OCC, 0);
        nxt();

        // Streaming with the consumer always ready.
        lat_chk = 1'b1; occ_max = 0; pops0 = pops;
        for (int i = 0; i < 3; i++) begin
            IN_VALID = 1'b1; IN_DATA = stream_vec[i];
            @(negedge CLK);
            nxt();
        end
        IN_VALID = 1'b0; lat_chk = 1'b0;
        repeat (5) nxt();
        chk("stream_occ_peak", occ_max, 3);
        chk("stream_pops", pops - pops0, 3);
        chk("stream_sb_empty", sb.size(), 0);

        // Backpressure: only S words fit while the consumer is stalled.
        OUT_READY = 1'b0; pops0 = pops;
        for (int i = 0; i < 5; i++) begin
            IN_VALID = 1'b1; IN_DATA = 32'h1000_0000 + i;
            @(negedge CLK);
            chk("bp_in_ready", IN_READY, bp_rdy[i]);
            nxt();
        end
        IN_VALID = 1'b0;
        @(negedge CLK);
        chk("bp_full_occ", OCC, 3);
        chk("bp_full_in_ready", IN_READY, 1'b0);
        chk("bp_out_valid", OUT_VALID, 1'b1);
        chk("bp_out_data", OUT_DATA, 32'h1000_0000);
        nxt();
        @(negedge CLK);
        chk("bp_out_stable", OUT_DATA, 32'h1000_0000);
        nxt();
        // Full with consumer ready: simultaneous in/out transfer.
        OUT_READY = 1'b1; IN_VALID = 1'b1; IN_DATA = 32'h1000_0005;
        @(negedge CLK);
        chk("full_pass_in_ready", IN_READY, 1'b1);
        nxt();
        IN_VALID = 1'b0;
        @(negedge CLK);
        chk("full_pass_occ", OCC, 3);
        repeat (6) nxt();
        chk("bp_pops", pops - pops0, 4);
        chk("bp_sb_empty", sb.size(), 0);
        chk("bp_drained_occ", OCC, 0);

        // Bubble collapse: a lone word runs to the last stage.
        OUT_READY = 1'b0;
        IN_VALID = 1'b1; IN_DATA = 32'h4080_0000;
        @(negedge CLK);
        nxt();
        IN_VALID = 1'b0;
        nxt(); nxt();
        @(negedge CLK);
        chk("bub_occ1", OCC, 1);
        chk("bub_out_valid", OUT_VALID, 1'b1);
        chk("bub_out_data", OUT_DATA, 32'h4080_0000);
        chk("bub_in_ready", IN_READY, 1'b1);
        nxt();
        IN_VALID = 1'b1; IN_DATA = 32'h40A0_0000;
        @(negedge CLK);
        chk("bub_accept", IN_READY, 1'b1);
        nxt();
        IN_VALID = 1'b0;
        @(negedge CLK);
        chk("bub_occ2", OCC, 2);
        nxt();
        @(negedge CLK);
        chk("bub_occ2_hold", OCC, 2);
        chk("bub_in_ready2", IN_READY, 1'b1);
        nxt();
        OUT_READY = 1'b1;
        repeat (5) nxt();
        chk("bub_sb_empty", sb.size(), 0);

        // Flush with IN_VALID and OUT_READY high: nothing transfers.
        OUT_READY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            IN_VALID = 1'b1; IN_DATA = 32'h2000_0000 + i;
            @(negedge CLK);
            nxt();
        end
        IN_VALID = 1'b0;
        @(negedge CLK);
        chk("fl_pre_occ", OCC, 3);
        nxt();
        FLUSH = 1'b1; IN_VALID = 1'b1; IN_DATA = 32'h2FFF_FFFF; OUT_READY = 1'b1;
        sb.delete();
        pops0 = pops;
        @(negedge CLK);
        chk("fl_in_ready", IN_READY, 1'b0);
        nxt();
        FLUSH = 1'b0; IN_VALID = 1'b0;
        @(negedge CLK);
        chk("fl_occ", OCC, 0);
        chk("fl_out_valid", OUT_VALID, 1'b0);
        repeat (4) nxt();
        chk("fl_no_transfer", pops - pops0, 0);

`ifdef FPU_PIPE_STALL_CNT_EN
        // Stall counter: exact counting, saturation and flush clear.
        OUT_READY = 1'b0;
        IN_VALID = 1'b1; IN_DATA = 32'h4100_0000;
        @(negedge CLK);
        nxt();
        IN_VALID = 1'b0;
        nxt(); nxt();
        @(negedge CLK);
        chk("stall_start", STALL_CNT, 16'd0);
        repeat (5) nxt();
        @(negedge CLK);
        chk("stall_five", STALL_CNT, 16'd5);
        repeat (70000) nxt();
        @(negedge CLK);
        chk("stall_sat", STALL_CNT, 16'hFFFF);
        nxt();
        FLUSH = 1'b1; sb.delete();
        nxt();
        FLUSH = 1'b0;
        @(negedge CLK);
        chk("stall_flush", STALL_CNT, 16'd0);
        nxt();
`endif

        chk("final_sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
